// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-requester SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned MAX_PEND_DEF = 8;
  localparam int unsigned NUM_RQ       = 2;

  typedef enum logic {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  typedef logic rq_id_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester ids for outstanding reads; DEPTH must be a power of 2.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_PEND_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  rq_id_t                   push_id_i,
  input  logic                     pop_i,
  output rq_id_t                   pop_id_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_en, rd_en;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign wr_en    = push_i && !full_o;
  assign rd_en    = pop_i && !empty_o;
  assign pop_id_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_en)      count_q <= count_q + CNT_W'(1);
      else if (rd_en && !wr_en) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-MM SDRAM master between two requesters and routes read beats back in order.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  rq_read,
  input  logic [1:0]                  rq_write,
  input  logic [2*ADDR_W-1:0]         rq_address,
  input  logic [2*DATA_W-1:0]         rq_writedata,
  input  logic [2*(DATA_W/8)-1:0]     rq_byteenable,
  output logic [1:0]                  rq_waitrequest,
  output logic [1:0]                  rq_readdatavalid,
  output logic [DATA_W-1:0]           rq_readdata,
  output logic                        read_n,
  output logic                        write_n,
  output logic                        chipselect,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W/8-1:0]         byteenable,
  output logic [DATA_W-1:0]           writedata,
  input  logic                        waitrequest,
  input  logic                        readdatavalid,
  input  logic [DATA_W-1:0]           readdata,
  output logic [$clog2(MAX_PEND):0]   pend_count,
  output logic                        err_underflow
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  rq_id_t              grant_q, grant_d, last_grant_q, last_grant_d, winner, pop_id;
  logic                read_n_q, read_n_d, write_n_q, write_n_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [NUM_RQ-1:0]   elig;
  logic                accept, fifo_full, fifo_empty;

  assign elig = rq_write | (rq_read & {NUM_RQ{!fifo_full}});

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign winner = elig[0] ? 1'b0 : 1'b1;
`else
  // Tie goes to whoever was not served last; otherwise the single eligible one.
  assign winner = (&elig) ? ~last_grant_q : elig[1];
`endif

  // Command FSM: latch the winner in ARB, hold it on the bus until the slave accepts.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    read_n_d     = read_n_q;
    write_n_d    = write_n_q;
    address_d    = address_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    accept       = 1'b0;
    case (state_q)
      ARB: begin
        if (|elig) begin
          grant_d   = winner;
          state_d   = ISSUE;
          address_d = winner ? rq_address[2*ADDR_W-1:ADDR_W] : rq_address[ADDR_W-1:0];
          wdata_d   = winner ? rq_writedata[2*DATA_W-1:DATA_W] : rq_writedata[DATA_W-1:0];
          be_d      = winner ? rq_byteenable[2*BE_W-1:BE_W] : rq_byteenable[BE_W-1:0];
          if (rq_write[winner]) write_n_d = 1'b0;
          else                  read_n_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (!waitrequest) begin
          accept       = 1'b1;
          read_n_d     = 1'b1;
          write_n_d    = 1'b1;
          last_grant_d = grant_q;
          state_d      = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    rq_waitrequest = 2'b11;
    if (accept && reset_n) rq_waitrequest[grant_q] = 1'b0;
  end

  // Read return path: each beat consumes the oldest tag.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (readdatavalid) begin
      if (fifo_empty) begin
        err_d = 1'b1;
      end else begin
        rvalid_d[pop_id] = 1'b1;
        rdata_d          = readdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ARB;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      read_n_q     <= 1'b1;
      write_n_q    <= 1'b1;
      address_q    <= '0;
      be_q         <= '1;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      read_n_q     <= read_n_d;
      write_n_q    <= write_n_d;
      address_q    <= address_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
    end
  end

  sdram_arb_tag_fifo #(.DEPTH(MAX_PEND)) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (accept && !read_n_q),
    .push_id_i (grant_q),
    .pop_i     (readdatavalid),
    .pop_id_o  (pop_id),
    .count_o   (pend_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign read_n           = read_n_q;
  assign write_n          = write_n_q;
  assign chipselect       = 1'b1;
  assign address          = address_q;
  assign byteenable       = be_q;
  assign writedata        = wdata_q;
  assign rq_readdata      = rdata_q;
  assign rq_readdatavalid = rvalid_q;
  assign err_underflow    = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected commands/beats are queued by the stimulus
// and popped by monitors; a small slave model returns read data with configurable latency.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      rq_read, rq_write;
  logic [2*AW-1:0] rq_address;
  logic [2*DW-1:0] rq_writedata;
  logic [2*BW-1:0] rq_byteenable;
  logic [1:0]      rq_waitrequest, rq_readdatavalid;
  logic [DW-1:0]   rq_readdata;
  logic            read_n, write_n, chipselect;
  logic [AW-1:0]   address;
  logic [BW-1:0]   byteenable;
  logic [DW-1:0]   writedata;
  logic            waitrequest, readdatavalid;
  logic [DW-1:0]   readdata;
  logic [3:0]      pend_count;
  logic            err_underflow;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .rq_read(rq_read), .rq_write(rq_write), .rq_address(rq_address),
    .rq_writedata(rq_writedata), .rq_byteenable(rq_byteenable),
    .rq_waitrequest(rq_waitrequest), .rq_readdatavalid(rq_readdatavalid),
    .rq_readdata(rq_readdata), .read_n(read_n), .write_n(write_n),
    .chipselect(chipselect), .address(address), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .pend_count(pend_count), .err_underflow(err_underflow)
  );

  typedef struct { bit we; bit id; logic [31:0] addr; logic [15:0] data; } cmd_t;
  typedef struct { logic [1:0] vld; logic [15:0] data; } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  int          cyc = 0;
  logic [31:0] sl_addr[$];
  int          sl_due[$];
  int          slv_lat = 3;
  int          slv_used = 0;
  int          slv_allow = 1 << 30;
  int          inj_req = 0;
  int          inj_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] slv_data(input logic [31:0] a);
    case (a)
      32'h5:   return 16'h1234;
      32'h10:  return 16'hAAAA;
      32'h11:  return 16'hBBBB;
      32'h12:  return 16'hCCCC;
      default: return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_cmd(input bit we, input bit id, input logic [31:0] a, input logic [15:0] d);
    cmd_t e;
    e.we = we; e.id = id; e.addr = a; e.data = d;
    cmd_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [1:0] v, input logic [15:0] d);
    rsp_t r;
    r.vld = v; r.data = d;
    rsp_q.push_back(r);
  endtask

  task automatic mon_cmd();
    cmd_t e;
    logic [1:0] wexp;
    forever begin
      @(negedge clk);
      if (reset_n && !waitrequest && (!read_n || !write_n)) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", {!write_n, address}, 0);
        end else begin
          e = cmd_q.pop_front();
          wexp = e.id ? 2'b01 : 2'b10;
          chk("cmd", {!write_n, address, rq_waitrequest, e.we ? writedata : 16'h0},
              {e.we, e.addr, wexp, e.we ? e.data : 16'h0});
        end
      end
    end
  endtask

  task automatic mon_rsp();
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rq_readdatavalid !== 2'b00) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_beat", {rq_readdatavalid, rq_readdata}, 0);
        end else begin
          r = rsp_q.pop_front();
          chk("beat", {rq_readdatavalid, rq_readdata}, {r.vld, r.data});
        end
      end
    end
  endtask

  task automatic slave();
    readdatavalid = 1'b0;
    readdata      = '0;
    forever begin
      @(negedge clk);
      if (reset_n && !read_n && !waitrequest) begin
        sl_addr.push_back(address);
        sl_due.push_back(cyc + slv_lat);
      end
      @(posedge clk);
      #1;
      readdatavalid = 1'b0;
      if (inj_done != inj_req) begin
        readdatavalid = 1'b1;
        readdata      = 16'hDEAD;
        inj_done++;
      end else if (sl_addr.size() > 0 && cyc >= sl_due[0] && slv_used < slv_allow) begin
        readdatavalid = 1'b1;
        readdata      = slv_data(sl_addr.pop_front());
        void'(sl_due.pop_front());
        slv_used++;
      end
    end
  endtask

  // Hold one command on requester id until its rq_waitrequest drops; returns 1 ns after the accept edge.
  task automatic req(input bit id, input bit we, input logic [31:0] a, input logic [15:0] d);
    int n = 0;
    if (id) begin
      rq_address[2*AW-1:AW] = a; rq_writedata[2*DW-1:DW] = d; rq_byteenable[2*BW-1:BW] = 2'b11;
    end else begin
      rq_address[AW-1:0] = a; rq_writedata[DW-1:0] = d; rq_byteenable[BW-1:0] = 2'b11;
    end
    rq_read[id]  = !we;
    rq_write[id] = we;
    do begin
      @(negedge clk);
      n++;
    end while (rq_waitrequest[id] && n < 300);
    chk("req_timeout", rq_waitrequest[id], 1'b0);
    @(posedge clk);
    #1;
    rq_read[id]  = 1'b0;
    rq_write[id] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((rsp_q.size() != 0 || cmd_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, rsp_q.size() + cmd_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    chk(name, {read_n, write_n, chipselect, address, byteenable, writedata, rq_waitrequest,
               rq_readdatavalid, rq_readdata, pend_count, err_underflow},
              {1'b1, 1'b1, 1'b1, 32'h0, 2'b11, 16'h0, 2'b11, 2'b00, 16'h0, 4'd0, 1'b0});
  endtask

  logic [15:0] t4_data [8] = '{16'h5A7A, 16'h5A7B, 16'h5A78, 16'h5A79,
                               16'h5A7E, 16'h5A7F, 16'h5A7C, 16'h5A7D};

  initial begin
    int n;
    reset_n = 1'b0; rq_read = '0; rq_write = '0; rq_address = '0;
    rq_writedata = '0; rq_byteenable = '1; waitrequest = 1'b0;
    fork
      mon_cmd();
      mon_rsp();
      slave();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_vals");
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single read, command one cycle after the request
    exp_cmd(1'b0, 1'b0, 32'h5, 16'h0);
    exp_rsp(2'b01, 16'h1234);
    rq_address[AW-1:0] = 32'h5;
    rq_read[0] = 1'b1;
    @(negedge clk);
    chk("t1_idle_read_n", read_n, 1'b1);
    @(negedge clk);
    chk("t1_cmd", {read_n, address, rq_waitrequest}, {1'b0, 32'h5, 2'b10});
    @(posedge clk); #1 rq_read[0] = 1'b0;
    drain("t1_drain");
    chk("t1_rdata", rq_readdata, 16'h1234);

    // 2: both read back to back; last grant was requester 0
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_cmd(0, 0, 32'h50, 0); exp_cmd(0, 0, 32'h52, 0); exp_cmd(0, 1, 32'h51, 0); exp_cmd(0, 1, 32'h53, 0);
    exp_rsp(2'b01, 16'h5A0A); exp_rsp(2'b01, 16'h5A08); exp_rsp(2'b10, 16'h5A0B); exp_rsp(2'b10, 16'h5A09);
`else
    exp_cmd(0, 1, 32'h51, 0); exp_cmd(0, 0, 32'h50, 0); exp_cmd(0, 1, 32'h53, 0); exp_cmd(0, 0, 32'h52, 0);
    exp_rsp(2'b10, 16'h5A0B); exp_rsp(2'b01, 16'h5A0A); exp_rsp(2'b10, 16'h5A09); exp_rsp(2'b01, 16'h5A08);
`endif
    fork
      begin req(1'b0, 1'b0, 32'h50, 16'h0); req(1'b0, 1'b0, 32'h52, 16'h0); end
      begin req(1'b1, 1'b0, 32'h51, 16'h0); req(1'b1, 1'b0, 32'h53, 16'h0); end
    join
    drain("t2_drain");

    // 3: write stalled by waitrequest for 5 cycles
    waitrequest = 1'b1;
    exp_cmd(1'b1, 1'b1, 32'h2, 16'hBEEF);
    rq_address[2*AW-1:AW] = 32'h2; rq_writedata[2*DW-1:DW] = 16'hBEEF;
    rq_byteenable[2*BW-1:BW] = 2'b01; rq_write[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold", {write_n, address, writedata, byteenable, rq_waitrequest},
                     {1'b0, 32'h2, 16'hBEEF, 2'b01, 2'b11});
    end
    @(posedge clk); #1 waitrequest = 1'b0;
    @(negedge clk);
    chk("t3_accept", rq_waitrequest, 2'b01);
    @(posedge clk); #1 rq_write[1] = 1'b0; rq_byteenable[2*BW-1:BW] = 2'b11;
    @(negedge clk);
    chk("t3_release", write_n, 1'b1);
    drain("t3_drain");

    // 4: fill the tag FIFO, 9th read stalls while a write passes
    slv_allow = slv_used;
    for (int i = 0; i < 8; i++) begin
      exp_cmd(1'b0, 1'b0, 32'h20 + 32'(i), 16'h0);
      exp_rsp(2'b01, t4_data[i]);
      req(1'b0, 1'b0, 32'h20 + 32'(i), 16'h0);
    end
    @(negedge clk);
    chk("t4_full", pend_count, 4'd8);
    @(posedge clk); #1;
    exp_cmd(1'b1, 1'b1, 32'h40, 16'h4444);
    exp_cmd(1'b0, 1'b0, 32'h30, 16'h0);
    exp_rsp(2'b01, 16'h5A6A);
    fork
      req(1'b0, 1'b0, 32'h30, 16'h0);
      begin
        req(1'b1, 1'b1, 32'h40, 16'h4444);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t4_stall", {read_n, pend_count}, {1'b1, 4'd8});
        end
        slv_allow = slv_used + 1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (pend_count != 4'd7 && n < 20);
        chk("t4_pop", pend_count, 4'd7);
      end
    join
    slv_allow = 1 << 30;
    drain("t4_drain");
    chk("t4_empty", pend_count, 4'd0);

    // 5: interleaved reads; first beat lands in the same cycle as the third accept
    slv_lat = 4;
    exp_cmd(0, 0, 32'h10, 0); exp_cmd(0, 1, 32'h11, 0); exp_cmd(0, 0, 32'h12, 0);
    exp_rsp(2'b01, 16'hAAAA); exp_rsp(2'b10, 16'hBBBB); exp_rsp(2'b01, 16'hCCCC);
    req(1'b0, 1'b0, 32'h10, 16'h0);
    req(1'b1, 1'b0, 32'h11, 16'h0);
    req(1'b0, 1'b0, 32'h12, 16'h0);
    @(negedge clk);
    chk("t5_pend_steady", pend_count, 4'd2);
    @(posedge clk); #1;
    drain("t5_drain");
    slv_lat = 3;

    // 6: underflow beat, then reset in the middle of an issue
    chk("t6_err_clear", err_underflow, 1'b0);
    inj_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_beat", rq_readdatavalid, 2'b00);
    end
    chk("t6_err_set", err_underflow, 1'b1);
    @(posedge clk); #1;
    waitrequest = 1'b1;
    rq_address[AW-1:0] = 32'h77; rq_writedata[DW-1:0] = 16'h7777; rq_write[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_issue", {write_n, address}, {1'b0, 32'h77});
    @(posedge clk); #1 reset_n = 1'b0; rq_write[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("t6_reset_vals");
    waitrequest = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
